// File: rtl/uart_cmd_scheduler.sv
// UART command scheduler: pops bytes from an RX FIFO, turns single-character
// commands into one-cycle pulses and optionally echoes each byte to a TX FIFO.
module uart_cmd_scheduler #(
  parameter int unsigned ECHO_UNKNOWN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_rd,
  input  logic       tx_full,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       echo_en,
  output logic       uart_0,
  output logic       uart_1,
  output logic       uart_2,
  output logic       uart_3,
  output logic       uart_Q,
  output logic       uart_F,
  output logic       uart_R,
  output logic       uart_W,
  output logic       uart_S,
  output logic       uart_A,
  output logic       uart_D,
  output logic       cmd_err,
  output logic [7:0] cmd_cnt
);

  localparam int ERR_BIT = 11;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    DECODE,
    ECHO
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  rx_byte_q;
  logic        known_q;
  logic [11:0] pulse_q;
  logic [11:0] rx_code;
  logic [7:0]  cmd_cnt_q;
  logic [7:0]  tx_data_q;
  logic        rx_rd_q;
  logic [7:0]  echo_byte;

  // One-hot command code; bit ERR_BIT flags a byte that is not a command.
  function automatic logic [11:0] decode_byte(input logic [7:0] b);
    logic [11:0] code;
    code = '0;
    case (b)
      8'h30:        code[0]       = 1'b1;
      8'h31:        code[1]       = 1'b1;
      8'h32:        code[2]       = 1'b1;
      8'h33:        code[3]       = 1'b1;
      8'h51, 8'h71: code[4]       = 1'b1;
      8'h46, 8'h66: code[5]       = 1'b1;
      8'h52, 8'h72: code[6]       = 1'b1;
      8'h57, 8'h77: code[7]       = 1'b1;
      8'h53, 8'h73: code[8]       = 1'b1;
      8'h41, 8'h61: code[9]       = 1'b1;
      8'h44, 8'h64: code[10]      = 1'b1;
      default:      code[ERR_BIT] = 1'b1;
    endcase
    return code;
  endfunction

  assign rx_code = decode_byte(rx_data);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_empty) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = DECODE;
      DECODE: begin
        if (echo_en && (known_q || (ECHO_UNKNOWN != 0))) begin
          state_d = ECHO;
        end else begin
          state_d = IDLE;
        end
      end
      ECHO:    if (!tx_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are decoded straight from rx_data in CAPTURE so they are registered
  // and land exactly in the DECODE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_rd_q   <= 1'b0;
      pulse_q   <= '0;
      rx_byte_q <= 8'h00;
      known_q   <= 1'b0;
      cmd_cnt_q <= 8'h00;
      tx_data_q <= 8'h00;
    end else begin
      rx_rd_q <= (state_d == READ);
      pulse_q <= (state_q == CAPTURE) ? rx_code : '0;
      if (state_q == CAPTURE) begin
        rx_byte_q <= rx_data;
        known_q   <= ~rx_code[ERR_BIT];
      end
      if (state_q == DECODE && known_q) begin
        cmd_cnt_q <= cmd_cnt_q + 8'd1;
      end
      if (tx_wr) begin
        tx_data_q <= echo_byte;
      end
    end
  end

  // tx_data shows the byte being pushed and otherwise the last byte pushed.
  always_comb begin
    echo_byte = known_q ? rx_byte_q : 8'h3F;
    tx_wr     = (state_q == ECHO) && !tx_full && rst;
    tx_data   = tx_wr ? echo_byte : tx_data_q;
  end

  assign rx_rd   = rx_rd_q;
  assign cmd_cnt = cmd_cnt_q;
  assign uart_0  = pulse_q[0];
  assign uart_1  = pulse_q[1];
  assign uart_2  = pulse_q[2];
  assign uart_3  = pulse_q[3];
  assign uart_Q  = pulse_q[4];
  assign uart_F  = pulse_q[5];
  assign uart_R  = pulse_q[6];
  assign uart_W  = pulse_q[7];
  assign uart_S  = pulse_q[8];
  assign uart_A  = pulse_q[9];
  assign uart_D  = pulse_q[10];
  assign cmd_err = pulse_q[ERR_BIT];

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Self-checking bench for uart_cmd_scheduler: a queue-based RX FIFO feeds
// bytes and a character-level model predicts pulses, echoes and the count.
module tb_uart_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       tx_full = 1'b0;
  logic       echo_en = 1'b0;
  logic       rx_rd, tx_wr, cmd_err;
  logic [7:0] tx_data, cmd_cnt;
  logic       uart_0, uart_1, uart_2, uart_3, uart_Q, uart_F;
  logic       uart_R, uart_W, uart_S, uart_A, uart_D;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  rxq[$];
  int          rdCyc[$];
  int          pulseCyc[$];
  logic [11:0] pulseVal[$];
  int          txCyc[$];
  logic [7:0]  txVal[$];
  int          txWhileFull = 0;
  int          popEmpty = 0;

  wire [11:0] pulseVec = {cmd_err, uart_D, uart_A, uart_S, uart_W, uart_R,
                          uart_F, uart_Q, uart_3, uart_2, uart_1, uart_0};

  uart_cmd_scheduler dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_full(tx_full), .tx_data(tx_data), .tx_wr(tx_wr), .echo_en(echo_en),
    .uart_0(uart_0), .uart_1(uart_1), .uart_2(uart_2), .uart_3(uart_3),
    .uart_Q(uart_Q), .uart_F(uart_F), .uart_R(uart_R), .uart_W(uart_W),
    .uart_S(uart_S), .uart_A(uart_A), .uart_D(uart_D), .cmd_err(cmd_err),
    .cmd_cnt(cmd_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RX FIFO model: a pop in one cycle presents the byte on rx_data for the next.
  always @(negedge clk) begin
    if (rx_rd === 1'b1) begin
      if (rxq.size() > 0) rx_data = rxq.pop_front();
      else popEmpty++;
    end
    rx_empty = (rxq.size() == 0);
  end

  always @(negedge clk) begin
    if (rx_rd === 1'b1) rdCyc.push_back(cyc);
    if (pulseVec != 12'd0) begin
      pulseCyc.push_back(cyc);
      pulseVal.push_back(pulseVec);
    end
    if (tx_wr === 1'b1) begin
      txCyc.push_back(cyc);
      txVal.push_back(tx_data);
      if (tx_full) txWhileFull++;
    end
  end

  // Character-level command map: bit i for the i-th letter of the table, bit 11 otherwise.
  function automatic logic [11:0] refCode(input logic [7:0] b);
    string cmds = "0123QFRWSAD";
    logic [7:0] u;
    logic [11:0] code;
    u = b;
    if (b >= 8'h61 && b <= 8'h7A) u = b - 8'h20;
    code = 12'h800;
    for (int i = 0; i < cmds.len(); i++) begin
      if (8'(cmds[i]) == u) code = 12'd1 << i;
    end
    return code;
  endfunction

  function automatic logic [7:0] randCmd();
    string valid = "0123QFRWSADqfrwsad";
    int idx;
    idx = int'($urandom_range(0, valid.len() - 1));
    return 8'(valid[idx]);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    rdCyc.delete();
    pulseCyc.delete();
    pulseVal.delete();
    txCyc.delete();
    txVal.delete();
  endtask

  task automatic doReset();
    rst = 1'b0;
    rxq.delete();
    tick(2);
    rst = 1'b1;
    clearLogs();
  endtask

  task automatic drain(input int budget);
    int quiet;
    int n;
    bit done;
    quiet = 0;
    n = 0;
    done = 1'b0;
    while (n < budget && !done) begin
      tick(1);
      n++;
      if (rx_rd || tx_wr || pulseVec != 12'd0) quiet = 0;
      else quiet++;
      if (rxq.size() == 0 && quiet >= 8) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL drain: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxq.push_back(8'h57);
    tick(3);
    checks++; if (rx_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_rd: got %b required 0", rx_rd); end
    checks++; if (tx_wr !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_wr: got %b required 0", tx_wr); end
    checks++; if (pulseVec !== 12'd0) begin failures++; $display("[TB] FAIL reset_pulses: got %h required 000", pulseVec); end
    checks++; if (cmd_cnt !== 8'h00) begin failures++; $display("[TB] FAIL reset_cmd_cnt: got %h required 00", cmd_cnt); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data: got %h required 00", tx_data); end
    checks++; if (rdCyc.size() != 0) begin failures++; $display("[TB] FAIL reset_no_pop: got %0d pops required 0", rdCyc.size()); end
    rxq.delete();
    rst = 1'b1;
    tick(2);
    clearLogs();
  endtask

  task automatic test_single_command();
    int c;
    doReset();
    echo_en = 1'b0;
    c = cyc;
    rxq.push_back(8'h57);
    drain(60);
    checks++; if (rdCyc.size() != 1 || rdCyc[0] != c + 1) begin failures++; $display("[TB] FAIL w_rd_timing: got %0d pops first at %0d required 1 at %0d", rdCyc.size(), rdCyc.size() > 0 ? rdCyc[0] : -1, c + 1); end
    checks++; if (pulseVal.size() != 1 || pulseCyc[0] != c + 3) begin failures++; $display("[TB] FAIL w_pulse_timing: got %0d pulses first at %0d required 1 at %0d", pulseVal.size(), pulseCyc.size() > 0 ? pulseCyc[0] : -1, c + 3); end
    checks++; if (pulseVal.size() < 1 || pulseVal[0] !== refCode(8'h57)) begin failures++; $display("[TB] FAIL w_pulse_value: got %h required %h", pulseVal.size() > 0 ? pulseVal[0] : 12'h0, refCode(8'h57)); end
    checks++; if (txVal.size() != 0) begin failures++; $display("[TB] FAIL w_no_echo: got %0d tx writes required 0", txVal.size()); end
    checks++; if (cmd_cnt !== 8'd1) begin failures++; $display("[TB] FAIL w_cmd_cnt: got %0d required 1", cmd_cnt); end
  endtask

  task automatic test_echo_command();
    int c;
    doReset();
    echo_en = 1'b1;
    c = cyc;
    rxq.push_back(8'h71);
    drain(60);
    checks++; if (pulseVal.size() != 1 || pulseVal[0] !== refCode(8'h71) || pulseCyc[0] != c + 3) begin failures++; $display("[TB] FAIL q_pulse: got %0d pulses first %h required %h at %0d", pulseVal.size(), pulseVal.size() > 0 ? pulseVal[0] : 12'h0, refCode(8'h71), c + 3); end
    checks++; if (txVal.size() != 1 || txCyc[0] != c + 4) begin failures++; $display("[TB] FAIL q_tx_timing: got %0d writes first at %0d required 1 at %0d", txVal.size(), txCyc.size() > 0 ? txCyc[0] : -1, c + 4); end
    checks++; if (txVal.size() < 1 || txVal[0] !== 8'h71) begin failures++; $display("[TB] FAIL q_tx_data: got %h required 71", txVal.size() > 0 ? txVal[0] : 8'h00); end
    checks++; if (tx_data !== 8'h71) begin failures++; $display("[TB] FAIL q_tx_hold: got %h required 71", tx_data); end
    checks++; if (cmd_cnt !== 8'd1) begin failures++; $display("[TB] FAIL q_cmd_cnt: got %0d required 1", cmd_cnt); end
  endtask

  // Runs straight after the 'q' test, so the count must stay at 1.
  task automatic test_unknown_byte();
    int c;
    clearLogs();
    echo_en = 1'b1;
    c = cyc;
    rxq.push_back(8'h7A);
    drain(60);
    checks++; if (pulseVal.size() != 1 || pulseVal[0] !== refCode(8'h7A) || pulseCyc[0] != c + 3) begin failures++; $display("[TB] FAIL z_err_pulse: got %0d pulses first %h required %h", pulseVal.size(), pulseVal.size() > 0 ? pulseVal[0] : 12'h0, refCode(8'h7A)); end
    checks++; if (txVal.size() != 1 || txVal[0] !== 8'h3F) begin failures++; $display("[TB] FAIL z_echo: got %0d writes first %h required 3f", txVal.size(), txVal.size() > 0 ? txVal[0] : 8'h00); end
    checks++; if (cmd_cnt !== 8'd1) begin failures++; $display("[TB] FAIL z_cmd_cnt: got %0d required 1", cmd_cnt); end
  endtask

  task automatic test_tx_full_stall();
    int d;
    doReset();
    echo_en = 1'b1;
    tx_full = 1'b1;
    rxq.push_back(8'h31);
    rxq.push_back(8'h32);
    tick(10);
    checks++; if (rdCyc.size() != 1) begin failures++; $display("[TB] FAIL stall_pops: got %0d required 1", rdCyc.size()); end
    checks++; if (pulseVal.size() != 1 || pulseVal[0] !== refCode(8'h31)) begin failures++; $display("[TB] FAIL stall_pulse: got %0d pulses first %h required %h", pulseVal.size(), pulseVal.size() > 0 ? pulseVal[0] : 12'h0, refCode(8'h31)); end
    checks++; if (txVal.size() != 0) begin failures++; $display("[TB] FAIL stall_no_tx: got %0d writes required 0", txVal.size()); end
    d = cyc;
    tx_full = 1'b0;
    drain(80);
    checks++; if (txVal.size() != 2 || txVal[0] !== 8'h31 || txCyc[0] != d) begin failures++; $display("[TB] FAIL stall_release_echo: got %0d writes first %h at %0d required 31 at %0d", txVal.size(), txVal.size() > 0 ? txVal[0] : 8'h00, txCyc.size() > 0 ? txCyc[0] : -1, d); end
    checks++; if (txVal.size() != 2 || txVal[1] !== 8'h32) begin failures++; $display("[TB] FAIL stall_second_echo: got %0d writes required second 32", txVal.size()); end
    checks++; if (pulseVal.size() != 2 || pulseVal[1] !== refCode(8'h32)) begin failures++; $display("[TB] FAIL stall_order: got %0d pulses required second %h", pulseVal.size(), refCode(8'h32)); end
    checks++; if (rdCyc.size() != 2 || rdCyc[1] != d + 2) begin failures++; $display("[TB] FAIL stall_second_pop: got %0d pops second at %0d required at %0d", rdCyc.size(), rdCyc.size() > 1 ? rdCyc[1] : -1, d + 2); end
    checks++; if (cmd_cnt !== 8'd2) begin failures++; $display("[TB] FAIL stall_cmd_cnt: got %0d required 2", cmd_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    int badIdx;
    int badGap;
    doReset();
    echo_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sent.push_back(randCmd());
      rxq.push_back(sent[i]);
    end
    drain(2000);
    badIdx = -1;
    badGap = -1;
    for (int i = 0; i < pulseVal.size() && i < 256; i++) begin
      if (badIdx < 0 && pulseVal[i] !== refCode(sent[i])) badIdx = i;
      if (badGap < 0 && i > 0 && pulseCyc[i] - pulseCyc[i-1] != 4) badGap = i;
    end
    checks++; if (pulseVal.size() != 256) begin failures++; $display("[TB] FAIL b2b_count: got %0d pulses required 256", pulseVal.size()); end
    checks++; if (badIdx >= 0) begin failures++; $display("[TB] FAIL b2b_sequence: byte %0d got %h required %h", badIdx, pulseVal[badIdx], refCode(sent[badIdx])); end
    checks++; if (badGap >= 0) begin failures++; $display("[TB] FAIL b2b_spacing: pulse %0d gap %0d required 4", badGap, pulseCyc[badGap] - pulseCyc[badGap-1]); end
    checks++; if (cmd_cnt !== 8'h00) begin failures++; $display("[TB] FAIL b2b_wrap: got %h required 00", cmd_cnt); end
    checks++; if (txVal.size() != 0) begin failures++; $display("[TB] FAIL b2b_no_echo: got %0d writes required 0", txVal.size()); end
  endtask

  task automatic test_reset_in_echo();
    doReset();
    echo_en = 1'b1;
    tx_full = 1'b1;
    rxq.push_back(8'h41);
    rxq.push_back(8'h53);
    tick(6);
    checks++; if (pulseVal.size() != 1 || pulseVal[0] !== refCode(8'h41)) begin failures++; $display("[TB] FAIL rie_first_pulse: got %0d pulses required %h", pulseVal.size(), refCode(8'h41)); end
    rst = 1'b0;
    tick(1);
    checks++; if (tx_wr !== 1'b0 || rx_rd !== 1'b0 || pulseVec !== 12'd0) begin failures++; $display("[TB] FAIL rie_strobes: got wr=%b rd=%b pulses=%h required 0", tx_wr, rx_rd, pulseVec); end
    checks++; if (cmd_cnt !== 8'h00 || tx_data !== 8'h00) begin failures++; $display("[TB] FAIL rie_regs: got cnt=%h tx_data=%h required 00", cmd_cnt, tx_data); end
    rst = 1'b1;
    tx_full = 1'b0;
    clearLogs();
    drain(60);
    checks++; if (txVal.size() != 1 || txVal[0] !== 8'h53) begin failures++; $display("[TB] FAIL rie_echo: got %0d writes first %h required 1 of 53", txVal.size(), txVal.size() > 0 ? txVal[0] : 8'h00); end
    checks++; if (pulseVal.size() != 1 || pulseVal[0] !== refCode(8'h53)) begin failures++; $display("[TB] FAIL rie_next_byte: got %0d pulses required %h", pulseVal.size(), refCode(8'h53)); end
    checks++; if (cmd_cnt !== 8'd1 || rdCyc.size() != 1) begin failures++; $display("[TB] FAIL rie_count: got cnt=%0d pops=%0d required 1 and 1", cmd_cnt, rdCyc.size()); end
  endtask

  task automatic test_random();
    int expCnt;
    doReset();
    expCnt = 0;
    tx_full = 1'b0;
    for (int batch = 0; batch < 2; batch++) begin
      logic [7:0]  pending[$];
      logic [11:0] expPulse[$];
      logic [7:0]  expTx[$];
      int n;
      int guard;
      int badP;
      int badT;
      int minGap;
      int fullBase;
      int emptyBase;
      clearLogs();
      fullBase = txWhileFull;
      emptyBase = popEmpty;
      echo_en = batch[0];
      for (int i = 0; i < 30; i++) begin
        logic [7:0] b;
        b = ($urandom_range(0, 1) == 0) ? randCmd() : 8'($urandom_range(0, 255));
        pending.push_back(b);
        expPulse.push_back(refCode(b));
        if (refCode(b) != 12'h800) expCnt++;
        if (echo_en) expTx.push_back(refCode(b) == 12'h800 ? 8'h3F : b);
      end
      n = pending.size();
      guard = 0;
      while (pending.size() > 0 && guard < 2000) begin
        tx_full = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) rxq.push_back(pending.pop_front());
        tick(1);
        guard++;
      end
      tx_full = 1'b0;
      drain(1000);
      badP = -1;
      badT = -1;
      minGap = 1000;
      for (int i = 0; i < pulseVal.size() && i < expPulse.size(); i++)
        if (badP < 0 && pulseVal[i] !== expPulse[i]) badP = i;
      for (int i = 0; i < txVal.size() && i < expTx.size(); i++)
        if (badT < 0 && txVal[i] !== expTx[i]) badT = i;
      for (int i = 1; i < rdCyc.size(); i++)
        if (rdCyc[i] - rdCyc[i-1] < minGap) minGap = rdCyc[i] - rdCyc[i-1];
      checks++; if (pulseVal.size() != expPulse.size() || badP >= 0) begin failures++; $display("[TB] FAIL rand_pulses echo=%0d: got %0d pulses first bad %0d required %0d matching", echo_en, pulseVal.size(), badP, expPulse.size()); end
      checks++; if (txVal.size() != expTx.size() || badT >= 0) begin failures++; $display("[TB] FAIL rand_echo echo=%0d: got %0d writes first bad %0d required %0d matching", echo_en, txVal.size(), badT, expTx.size()); end
      checks++; if (rdCyc.size() != n) begin failures++; $display("[TB] FAIL rand_pops echo=%0d: got %0d required %0d", echo_en, rdCyc.size(), n); end
      checks++; if (minGap < (echo_en ? 5 : 4)) begin failures++; $display("[TB] FAIL rand_spacing echo=%0d: got min gap %0d required >= %0d", echo_en, minGap, echo_en ? 5 : 4); end
      checks++; if (txWhileFull != fullBase || popEmpty != emptyBase) begin failures++; $display("[TB] FAIL rand_flow echo=%0d: got %0d writes while full %0d pops while empty required 0", echo_en, txWhileFull - fullBase, popEmpty - emptyBase); end
      checks++; if (cmd_cnt !== 8'(expCnt)) begin failures++; $display("[TB] FAIL rand_cmd_cnt echo=%0d: got %0d required %0d", echo_en, cmd_cnt, expCnt % 256); end
    end
  endtask

  initial begin
    $display("[TB] uart_cmd_scheduler bench start");
    test_reset();
    test_single_command();
    test_echo_command();
    test_unknown_byte();
    test_tx_full_stall();
    test_back_to_back();
    test_reset_in_echo();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_scheduler.md
UART_CMD_SCHEDULER -- requirements
Module: uart_cmd_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low: port rst, asserted when rst==0 and sampled only on the rising edge of clk.
REQ-002 The block SHALL have parameter ECHO_UNKNOWN, default 1, meaning an unrecognised byte is echoed as ASCII '?' (8'h3F) rather than dropped.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 rx_empty  input  1  RX FIFO empty flag.
REQ-006 rx_data  input  8  RX FIFO read data, valid the cycle after rx_rd.
REQ-007 rx_rd  output  1  RX FIFO pop strobe, one cycle wide.
REQ-008 tx_full  input  1  TX FIFO full flag.
REQ-009 tx_data  output  8  TX FIFO write data.
REQ-010 tx_wr  output  1  TX FIFO push strobe, one cycle wide.
REQ-011 echo_en  input  1  when 1, every consumed byte is echoed to TX.
REQ-012 uart_0, uart_1, uart_2, uart_3, uart_Q, uart_F, uart_R, uart_W, uart_S, uart_A, uart_D  output  1 each  one-cycle command pulses to the command controller.
REQ-013 cmd_err  output  1  one-cycle pulse on an unrecognised byte.
REQ-014 cmd_cnt  output  8  count of recognised commands, wraps 255->0.

Function
REQ-015 The block SHALL implement the FSM states IDLE, READ, CAPTURE, DECODE, ECHO.
REQ-016 In IDLE with rx_empty==0, the FSM SHALL go to READ; with rx_empty==1 it SHALL stay in IDLE.
REQ-017 rx_rd SHALL be 1 only in READ, for exactly one cycle per byte; READ SHALL always go to CAPTURE.
REQ-018 In CAPTURE, rx_data SHALL be registered into an internal byte register, and the FSM SHALL go to DECODE.
REQ-019 In DECODE, exactly one pulse output SHALL be 1 for that single cycle, per this map:
- '0','1','2','3' -> uart_0..uart_3
- 'Q'/'q' -> uart_Q; 'F'/'f' -> uart_F; 'R'/'r' -> uart_R
- 'W'/'w' -> uart_W; 'S'/'s' -> uart_S; 'A'/'a' -> uart_A; 'D'/'d' -> uart_D
- any other value -> cmd_err
REQ-020 All pulse outputs and cmd_err SHALL be registered, glitch-free and 0 outside DECODE.
REQ-021 cmd_cnt SHALL increment by 1 in the cycle after a recognised DECODE and SHALL NOT change on cmd_err.
REQ-022 From DECODE, the FSM SHALL go to ECHO if echo_en==1 (sampled in DECODE), else to IDLE.
- Exception: an unknown byte with ECHO_UNKNOWN==0 SHALL go to IDLE.
REQ-023 In ECHO with tx_full==0, tx_wr SHALL be 1 for one cycle, and the FSM SHALL go to IDLE.
- tx_data SHALL be the captured byte, or 8'h3F for an unknown byte.
REQ-024 In ECHO with tx_full==1, the FSM SHALL hold in ECHO with tx_wr==0 and no RX pops until tx_full falls.
REQ-025 Latency: rx_empty low at edge k gives rx_rd high in cycle k+1, the byte captured at edge k+2, and the pulse high in cycle k+3.
- Minimum spacing SHALL be 4 cycles per byte without echo and 5 with echo.
REQ-026 Bytes SHALL be processed strictly in FIFO order; no byte SHALL be skipped or popped twice.
REQ-027 A change of echo_en outside DECODE SHALL NOT affect a byte already past DECODE.
REQ-028 tx_data SHALL hold its last value when tx_wr==0.

Reset
REQ-029 When rst==0 at a clock edge, the next state SHALL be IDLE, with:
- rx_rd, tx_wr, all pulses and cmd_err at 0
- tx_data 8'h00, cmd_cnt 8'h00, byte register 8'h00
REQ-030 Reset asserted in any state, including ECHO with a pending echo, SHALL abandon the byte with no pulse and no tx_wr afterwards.
REQ-031 The uart_R pulse SHALL NOT reset this block; cmd_cnt SHALL continue counting.

Verification
REQ-032 Reset, then push 'W' (8'h57) with echo_en=0 -> rx_rd in cycle k+1; uart_W high exactly one cycle at k+3; tx_wr never asserts; cmd_cnt=1.
REQ-033 echo_en=1, push 'q' -> uart_Q pulse, then tx_wr one cycle later with tx_data=8'h71; cmd_cnt=1.
REQ-034 echo_en=1, push 8'h7A ('z') -> cmd_err pulse, no command pulse, tx_data=8'h3F, cmd_cnt unchanged.
REQ-035 echo_en=1, tx_full held 1 for 10 cycles, push '1' then '2' -> uart_1 pulses; no tx_wr and no second rx_rd until tx_full falls; then echo 8'h31, then '2' is processed in order.
REQ-036 Push 256 valid commands back-to-back with echo_en=0 -> one pulse every 4 cycles, and cmd_cnt wraps to 8'h00.
REQ-037 Assert rst=0 during ECHO with tx_full=1 -> the state returns to IDLE, no tx_wr, all outputs at reset values, and the next FIFO byte is decoded normally.
